// File: rtl/din_syn_pkg.sv
// rtl/din_syn_pkg.sv - shared states, clr_mode codes and frame constants for the din/syn sequencer
package din_syn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } seq_state_e;

  localparam logic [1:0] CLR_NORMAL = 2'b00;
  localparam logic [1:0] CLR_ONES   = 2'b01;
  localparam logic [1:0] CLR_ZEROS  = 2'b11;

  // Shifter frame payload length; a full frame takes FRAME_BITS+2 cycles.
  localparam int FRAME_BITS = 490;

  // Power of two comfortably above a whole frame (2048 for 490 bits).
  localparam int DEFAULT_TIMEOUT = 1 << $clog2(4 * FRAME_BITS);

  // Only 01 selects all-ones blanking; every other code blanks to zeros.
  function automatic logic [1:0] blank_norm(input logic [1:0] mode);
    return (mode == CLR_ONES) ? CLR_ONES : CLR_ZEROS;
  endfunction

  // States in which the frame's clr_mode must be presented to the shifter.
  function automatic logic in_frame(input seq_state_e st);
    return (st == S_SETUP) || (st == S_TRIG) || (st == S_WAIT_ACK) || (st == S_WAIT_DONE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with asynchronous active-high reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of an asynchronous level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/din_syn_sequencer.sv
// rtl/din_syn_sequencer.sv - frame scheduler driving the serial pattern shifter trig/clr_mode
module din_syn_sequencer
  import din_syn_pkg::*;
#(
  parameter int TRIG_W  = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 16
) (
  input  logic             clk_in,
  input  logic             dump,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_first,
  input  logic [1:0]       blank_mode,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             shf_out_en,
  output logic             trig,
  output logic [1:0]       clr_mode,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_W - 1);

  seq_state_e       state, next_state;
  logic             out_en_s;
  logic             is_blank, next_blank;
  logic [1:0]       bmode_q, next_bmode, next_clr;
  logic [CNT_W-1:0] rem_q;
  logic [GAP_W-1:0] gap_q, gcnt;
  logic [TW-1:0]    tcnt;
  logic             accept, frame_end, tmo_hit;

  sync_2ff #(.WIDTH(1)) u_out_en_sync (
    .clk (clk_in),
    .rst (dump),
    .d   (shf_out_en),
    .q   (out_en_s)
  );

  // Next-state decode: abort dominates, then frame progress, then timeout.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    frame_end  = 1'b0;
    tmo_hit    = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            accept     = 1'b1;
            next_state = S_SETUP;
          end
        end
        S_SETUP: next_state = S_TRIG;
        S_TRIG: begin
          if (tcnt == TMO_LAST) begin
            tmo_hit = 1'b1;
          end else if (tcnt == TRIG_LAST) begin
            // A fast shifter may already be running; skip the ack wait then.
            next_state = out_en_s ? S_WAIT_DONE : S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (out_en_s) begin
            next_state = S_WAIT_DONE;
          end else if (tcnt == TMO_LAST) begin
            tmo_hit = 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!out_en_s) begin
            frame_end = 1'b1;
            if (!is_blank && rem_q == '0) begin
              next_state = S_FINISH;
            end else if (gap_q == '0) begin
              next_state = S_SETUP;
            end else begin
              next_state = S_GAP;
            end
          end else if (tcnt == TMO_LAST) begin
            tmo_hit = 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == gap_q - GAP_W'(1)) begin
            next_state = S_SETUP;
          end
        end
        S_FINISH: next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
      if (tmo_hit) begin
        next_state = S_IDLE;
      end
    end
    // Every frame after the first completed one is a data frame.
    next_blank = accept ? clr_first : (frame_end ? 1'b0 : is_blank);
    next_bmode = accept ? blank_norm(blank_mode) : bmode_q;
    next_clr   = CLR_NORMAL;
    if (in_frame(next_state) && next_blank) begin
      next_clr = next_bmode;
    end
  end

  // State, counters and registered outputs, all decoded from next_state.
  always_ff @(posedge clk_in or posedge dump) begin
    if (dump) begin
      state       <= S_IDLE;
      trig        <= 1'b0;
      clr_mode    <= CLR_NORMAL;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      frames_sent <= '0;
      is_blank    <= 1'b0;
      bmode_q     <= CLR_NORMAL;
      rem_q       <= '0;
      gap_q       <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      state    <= next_state;
      trig     <= (next_state == S_TRIG);
      clr_mode <= next_clr;
      busy     <= (next_state != S_IDLE);
      done     <= (next_state == S_FINISH);
      is_blank <= next_blank;
      bmode_q  <= next_bmode;

      if (accept) begin
        rem_q       <= repeat_cnt;
        gap_q       <= gap_cycles;
        frames_sent <= '0;
        err_timeout <= 1'b0;
      end
      if (frame_end && !is_blank) begin
        frames_sent <= frames_sent + CNT_W'(1);
        if (rem_q != '0) begin
          rem_q <= rem_q - CNT_W'(1);
        end
      end
      if (tmo_hit) begin
        err_timeout <= 1'b1;
      end

      // Timeout/trig-width counter runs from trig rise until the frame ends.
      if ((state == S_TRIG || state == S_WAIT_ACK || state == S_WAIT_DONE) &&
          (next_state == S_TRIG || next_state == S_WAIT_ACK || next_state == S_WAIT_DONE)) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end

      if (state == S_GAP && next_state == S_GAP) begin
        gcnt <= gcnt + GAP_W'(1);
      end else begin
        gcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_din_syn_sequencer.sv
// tb/tb_din_syn_sequencer.sv - scoreboard bench for din_syn_sequencer with a behavioural shifter
module tb_din_syn_sequencer;

  localparam int TRIG_W  = 4;
  localparam int TIMEOUT = 2048;
  localparam int K_TRIG  = 0;
  localparam int K_DONE  = 1;
  localparam int K_TMO   = 2;

  typedef struct {
    int         kind;
    logic [1:0] clr;
    int         val;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       dump, start, abort, clr_first, shf_out_en;
  logic [1:0] blank_mode, clr_mode;
  logic [7:0] repeat_cnt, frames_sent;
  logic [15:0] gap_cycles;
  logic       trig, busy, done, err_timeout;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_trig = 0;
  int   rise_cyc = 0;
  int   last_fall = -100000;
  logic m_trig = 1'b0, m_err = 1'b0, m_oe = 1'b0;
  logic [1:0] m_clr = 2'b00;

  int   sh_cnt = 0, sh_len = 492, sh_dly = 2;
  bit   sh_enable = 1'b1;
  logic sh_trig_q = 1'b0;
  int   base;

  din_syn_sequencer #(
    .TRIG_W  (TRIG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8),
    .GAP_W   (16)
  ) dut (
    .clk_in      (clk_in),
    .dump        (dump),
    .start       (start),
    .abort       (abort),
    .clr_first   (clr_first),
    .blank_mode  (blank_mode),
    .repeat_cnt  (repeat_cnt),
    .gap_cycles  (gap_cycles),
    .shf_out_en  (shf_out_en),
    .trig        (trig),
    .clr_mode    (clr_mode),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .frames_sent (frames_sent)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [1:0] clr, input int val);
    exp_t x;
    x.kind = kind;
    x.clr  = clr;
    x.val  = val;
    exp_q.push_back(x);
  endtask

  task automatic do_start(input logic cf, input logic [1:0] bm, input logic [7:0] rep,
                          input logic [15:0] gap);
    @(negedge clk_in);
    clr_first  = cf;
    blank_mode = bm;
    repeat_cnt = rep;
    gap_cycles = gap;
    start      = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_within_budget", busy, 1'b0);
  endtask

  task automatic wait_trigs(input int k, input int budget);
    int n = 0;
    while (n_trig < k && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("trig_seen_within_budget", (n_trig >= k), 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((sh_cnt != 0 || shf_out_en) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("shifter_quiet", shf_out_en, 1'b0);
  endtask

  // Behavioural shifter: after sh_dly cycles, out_en high for sh_len cycles per trig.
  initial begin
    shf_out_en = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (dump) begin
        sh_cnt     = 0;
        shf_out_en = 1'b0;
        sh_trig_q  = 1'b0;
      end else begin
        if (trig && !sh_trig_q && sh_enable && sh_cnt == 0) sh_cnt = sh_dly + sh_len;
        else if (sh_cnt > 0) sh_cnt--;
        shf_out_en = (sh_cnt > 0 && sh_cnt <= sh_len);
        sh_trig_q  = trig;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a trig, done or timeout.
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (dump) begin
        m_trig = 1'b0;
        m_err  = 1'b0;
        m_oe   = 1'b0;
        m_clr  = 2'b00;
      end else begin
        if (m_oe && !shf_out_en) last_fall = cyc;
        if (trig && !m_trig) begin
          n_trig++;
          rise_cyc = cyc;
          if (exp_q.size() == 0) check("unexpected_trig", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("trig_event_kind", K_TRIG, e.kind);
            check("trig_clr_mode", clr_mode, e.clr);
            check("setup_clr_mode", m_clr, e.clr);
            if (e.val > 0) check("gap_min_cycles", (cyc - last_fall >= e.val), 1);
          end
        end
        if (!trig && m_trig) check("trig_width", cyc - rise_cyc, TRIG_W);
        if (done) begin
          if (exp_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("done_event_kind", K_DONE, e.kind);
            check("done_frames_sent", frames_sent, e.val);
            check("done_busy", busy, 1'b1);
          end
        end
        if (err_timeout && !m_err) begin
          if (exp_q.size() == 0) check("unexpected_timeout", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("tmo_event_kind", K_TMO, e.kind);
            check("tmo_latency", cyc - rise_cyc, TIMEOUT);
            check("tmo_trig_low", trig, 1'b0);
            check("tmo_busy_low", busy, 1'b0);
            check("tmo_clr_normal", clr_mode, 2'b00);
          end
        end
        m_trig = trig;
        m_err  = err_timeout;
        m_oe   = shf_out_en;
        m_clr  = clr_mode;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dump = 1'b1; start = 1'b0; abort = 1'b0; clr_first = 1'b0;
    blank_mode = 2'b00; repeat_cnt = 8'd0; gap_cycles = 16'd0;
    repeat (3) @(negedge clk_in);
    check("rst_trig", trig, 1'b0);
    check("rst_clr_mode", clr_mode, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_frames", frames_sent, 8'd0);
    dump = 1'b0;

    // Single data frame, no blanking, no gap.
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_DONE, 2'b00, 1);
    do_start(1'b0, 2'b00, 8'd0, 16'd0);
    check("t1_busy_after_start", busy, 1'b1);
    wait_idle(2000);
    check("t1_frames", frames_sent, 8'd1);
    wait_quiet(100);

    // Blanking frame (zeros) then three data frames with a 10-cycle gap.
    push_exp(K_TRIG, 2'b11, 0);
    push_exp(K_TRIG, 2'b00, 10);
    push_exp(K_TRIG, 2'b00, 10);
    push_exp(K_TRIG, 2'b00, 10);
    push_exp(K_DONE, 2'b00, 3);
    do_start(1'b1, 2'b11, 8'd2, 16'd10);
    wait_idle(5000);
    check("t2_frames", frames_sent, 8'd3);
    check("t2_clr_idle", clr_mode, 2'b00);
    wait_quiet(100);

    // blank_mode=10 blanks to zeros; fast shifter skips the ack wait.
    sh_dly = 0; sh_len = 60;
    push_exp(K_TRIG, 2'b11, 0);
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_DONE, 2'b00, 1);
    do_start(1'b1, 2'b10, 8'd0, 16'd0);
    wait_idle(1000);
    check("t2b_frames", frames_sent, 8'd1);
    wait_quiet(100);

    // All-ones blanking code passes through unchanged.
    sh_dly = 2;
    push_exp(K_TRIG, 2'b01, 0);
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_DONE, 2'b00, 1);
    do_start(1'b1, 2'b01, 8'd0, 16'd0);
    wait_idle(1000);
    wait_quiet(100);

    // Shifter never answers: timeout, no done, sticky flag.
    sh_enable = 1'b0;
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_TMO, 2'b00, 0);
    do_start(1'b0, 2'b00, 8'd0, 16'd0);
    wait_idle(3000);
    repeat (5) @(negedge clk_in);
    check("t3_err_sticky", err_timeout, 1'b1);
    check("t3_frames", frames_sent, 8'd0);

    // Abort during the second of four frames.
    sh_enable = 1'b1; sh_len = 100;
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_TRIG, 2'b00, 5);
    base = n_trig;
    do_start(1'b0, 2'b00, 8'd3, 16'd5);
    check("t4_err_cleared", err_timeout, 1'b0);
    wait_trigs(base + 2, 1000);
    repeat (20) @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_trig", trig, 1'b0);
    check("t4_clr_mode", clr_mode, 2'b00);
    check("t4_frames", frames_sent, 8'd1);
    wait_quiet(500);
    repeat (10) @(negedge clk_in);

    // Start while busy is ignored; start with abort in IDLE is dropped.
    sh_len = 50;
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_DONE, 2'b00, 1);
    base = n_trig;
    do_start(1'b0, 2'b00, 8'd0, 16'd0);
    repeat (10) @(negedge clk_in);
    do_start(1'b1, 2'b01, 8'd5, 16'd0);
    wait_idle(1000);
    check("t5_frames", frames_sent, 8'd1);
    wait_quiet(200);
    @(negedge clk_in);
    start = 1'b1; abort = 1'b1;
    @(negedge clk_in);
    start = 1'b0; abort = 1'b0;
    check("t5_abort_beats_start", busy, 1'b0);
    repeat (30) @(negedge clk_in);
    check("t5_no_extra_trig", n_trig, base + 1);

    // Asynchronous dump in the middle of the second frame.
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_TRIG, 2'b00, 0);
    base = n_trig;
    do_start(1'b0, 2'b00, 8'd1, 16'd0);
    wait_trigs(base + 2, 1000);
    repeat (30) @(negedge clk_in);
    check("t6_frames_before_dump", frames_sent, 8'd1);
    check("t6_busy_before_dump", busy, 1'b1);
    @(posedge clk_in);
    #3;
    dump = 1'b1;
    #1;
    check("t6_dump_busy", busy, 1'b0);
    check("t6_dump_frames", frames_sent, 8'd0);
    check("t6_dump_trig", trig, 1'b0);
    check("t6_dump_clr", clr_mode, 2'b00);
    repeat (2) @(negedge clk_in);
    dump = 1'b0;
    push_exp(K_TRIG, 2'b00, 0);
    push_exp(K_DONE, 2'b00, 1);
    do_start(1'b0, 2'b00, 8'd0, 16'd0);
    wait_idle(1000);
    check("t6_clean_frames", frames_sent, 8'd1);

    repeat (10) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
